// File: rtl/axis_lane_mux.sv
// axis_lane_mux
// -------------
// N-lane AXI-Stream packet multiplexer. Lanes are arbitrated only at packet
// boundaries (round-robin or fixed priority); the granted lane's frame is
// forwarded beat by beat into a two-entry output buffer (output register +
// one skid register) that drives the TX stream with full backpressure.
//
// Ports:
//   tx_clk, tx_rst_n     clock, asynchronous active-low reset
//   s_axis_t*            LANES packed input streams (lane i in slice i)
//   s_axis_tready        per-lane ready, only the granted lane can be high
//   m_axis_t*            registered output stream
//   grant_valid          a lane is locked (packet in progress)
//   grant_lane           currently or most recently granted lane
module axis_lane_mux #(
  parameter int LANES    = 2,
  parameter int DATA_W   = 32,
  parameter int KEEP_W   = DATA_W / 8,
  parameter int ARB_MODE = 0,
  localparam int LANE_W  = $clog2(LANES)
) (
  input  logic                       tx_clk,
  input  logic                       tx_rst_n,
  input  logic [LANES-1:0]           s_axis_tvalid,
  input  logic [LANES*DATA_W-1:0]    s_axis_tdata,
  input  logic [LANES*KEEP_W-1:0]    s_axis_tkeep,
  input  logic [LANES-1:0]           s_axis_tlast,
  output logic [LANES-1:0]           s_axis_tready,
  output logic                       m_axis_tvalid,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [KEEP_W-1:0]          m_axis_tkeep,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic                       grant_valid,
  output logic [LANE_W-1:0]          grant_lane
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [LANE_W-1:0]   grant_lane_reg;
  logic [LANE_W-1:0]   rr_ptr_reg;

  logic                out_valid_reg;
  logic [DATA_W-1:0]   out_data_reg;
  logic [KEEP_W-1:0]   out_keep_reg;
  logic                out_last_reg;
  logic                skid_valid_reg;
  logic [DATA_W-1:0]   skid_data_reg;
  logic [KEEP_W-1:0]   skid_keep_reg;
  logic                skid_last_reg;

  // Reset asserts asynchronously but is released on a clock edge so that
  // every flop leaves reset in the same cycle.
  logic rst_meta_reg, rst_n_reg;

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      rst_meta_reg <= 1'b0;
      rst_n_reg    <= 1'b0;
    end else begin
      rst_meta_reg <= 1'b1;
      rst_n_reg    <= rst_meta_reg;
    end
  end

  // Per-lane slices of the packed input buses.
  logic [DATA_W-1:0] lane_data [LANES];
  logic [KEEP_W-1:0] lane_keep [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_data[gi] = s_axis_tdata[gi*DATA_W +: DATA_W];
    assign lane_keep[gi] = s_axis_tkeep[gi*KEEP_W +: KEEP_W];
  end

  logic              sel_valid, sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;

  assign sel_valid = s_axis_tvalid[grant_lane_reg];
  assign sel_last  = s_axis_tlast[grant_lane_reg];
  assign sel_data  = lane_data[grant_lane_reg];
  assign sel_keep  = lane_keep[grant_lane_reg];

  // Internal ready is simply "skid empty": with one free slot guaranteed we
  // can always take a beat this cycle regardless of downstream ready.
  logic int_ready, accept, consume;

  assign int_ready = ~skid_valid_reg;
  assign accept    = (state_reg == LOCKED) & sel_valid & int_ready;
  assign consume   = out_valid_reg & m_axis_tready;

  // Arbiter. The loop scans offsets from high to low so the last hit, which
  // wins, is the first requester at or after the start point.
  logic [LANE_W-1:0] arb_lane;
  logic              arb_hit;
  logic [LANE_W:0]   arb_sum;
  logic [LANE_W-1:0] arb_idx;

  always_comb begin
    arb_lane = '0;
    arb_hit  = 1'b0;
    arb_sum  = '0;
    arb_idx  = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (ARB_MODE == 0) begin
        arb_sum = {1'b0, rr_ptr_reg} + (LANE_W+1)'(k);
        if (arb_sum >= (LANE_W+1)'(LANES)) begin
          arb_sum = arb_sum - (LANE_W+1)'(LANES);
        end
        arb_idx = arb_sum[LANE_W-1:0];
      end else begin
        arb_idx = LANE_W'(k);
      end
      if (s_axis_tvalid[arb_idx]) begin
        arb_lane = arb_idx;
        arb_hit  = 1'b1;
      end
    end
  end

  logic [LANE_W-1:0] grant_succ;

  assign grant_succ = (grant_lane_reg == LANE_W'(LANES - 1)) ? '0
                                                             : grant_lane_reg + 1'b1;

  // State register.
  always_ff @(posedge tx_clk or negedge rst_n_reg) begin
    if (!rst_n_reg) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_hit) state_next = LOCKED;
      LOCKED:  if (accept && sel_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    s_axis_tready = '0;
    grant_valid   = 1'b0;
    if (state_reg == LOCKED) begin
      s_axis_tready[grant_lane_reg] = int_ready;
      grant_valid                   = 1'b1;
    end
  end

  // Grant and round-robin pointer.
  always_ff @(posedge tx_clk or negedge rst_n_reg) begin
    if (!rst_n_reg) begin
      grant_lane_reg <= '0;
      rr_ptr_reg     <= '0;
    end else begin
      if (state_reg == IDLE && arb_hit) begin
        grant_lane_reg <= arb_lane;
      end
      if (ARB_MODE == 0 && accept && sel_last) begin
        rr_ptr_reg <= grant_succ;
      end
    end
  end

  // Output register plus skid register. An accepted beat only lands in the
  // skid when the output is occupied and not draining; accept implies the
  // skid was empty, so the skid never needs to shift and load together.
  always_ff @(posedge tx_clk or negedge rst_n_reg) begin
    if (!rst_n_reg) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_keep_reg   <= '0;
      out_last_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_keep_reg  <= '0;
      skid_last_reg  <= 1'b0;
    end else if (accept) begin
      if (!out_valid_reg || consume) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= sel_data;
        out_keep_reg  <= sel_keep;
        out_last_reg  <= sel_last;
      end else begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= sel_data;
        skid_keep_reg  <= sel_keep;
        skid_last_reg  <= sel_last;
      end
    end else if (consume) begin
      if (skid_valid_reg) begin
        out_data_reg   <= skid_data_reg;
        out_keep_reg   <= skid_keep_reg;
        out_last_reg   <= skid_last_reg;
        skid_valid_reg <= 1'b0;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = out_valid_reg;
  assign m_axis_tdata  = out_data_reg;
  assign m_axis_tkeep  = out_keep_reg;
  assign m_axis_tlast  = out_last_reg;
  assign grant_lane    = grant_lane_reg;

endmodule

// File: tb/tb_axis_lane_mux.sv
// Bench for axis_lane_mux: a round-robin and a fixed-priority instance
// (LANES=4, DATA_W=32), each fed by its own random frame sources and a
// random/pattern downstream ready, checked against a beat-queue model.
module tb_axis_lane_mux;

  localparam int LANES  = 4;
  localparam int DATA_W = 32;
  localparam int KEEP_W = 4;
  localparam int LANE_W = 2;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    logic              l;
    int                ln;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus knobs shared by both instances.
  bit             allow_new  = 1'b0;
  int             start_pct  = 0;
  int             len_min    = 1;
  int             len_max    = 1;
  bit             incr       = 1'b0;
  int             gap_pct    = 0;
  int             ready_mode = 0;
  logic [LANES-1:0] lane_mask = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_knobs(input bit an, input int sp, input int lmin, input int lmax,
                           input bit inc, input int gp, input int rm,
                           input logic [LANES-1:0] mask);
    allow_new  = an;
    start_pct  = sp;
    len_min    = lmin;
    len_max    = lmax;
    incr       = inc;
    gap_pct    = gp;
    ready_mode = rm;
    lane_mask  = mask;
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    logic [LANES-1:0]        s_tvalid = '0;
    logic [LANES*DATA_W-1:0] s_tdata  = '0;
    logic [LANES*KEEP_W-1:0] s_tkeep  = '0;
    logic [LANES-1:0]        s_tlast  = '0;
    logic [LANES-1:0]        s_tready;
    logic                    m_tvalid;
    logic [DATA_W-1:0]       m_tdata;
    logic [KEEP_W-1:0]       m_tkeep;
    logic                    m_tlast;
    logic                    m_tready = 1'b0;
    logic                    gvalid;
    logic [LANE_W-1:0]       glane;

    axis_lane_mux #(
      .LANES(LANES), .DATA_W(DATA_W), .KEEP_W(KEEP_W), .ARB_MODE(gi)
    ) u_dut (
      .tx_clk(clk),
      .tx_rst_n(rst_n),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep),
      .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tdata(m_tdata),
      .m_axis_tkeep(m_tkeep),
      .m_axis_tlast(m_tlast),
      .m_axis_tready(m_tready),
      .grant_valid(gvalid),
      .grant_lane(glane)
    );

    // Reference model: beats held inside the mux, in order, plus the
    // packet-level grant state derived from the arbitration rules.
    beat_t            q[$];
    bit               locked = 1'b0;
    int               lane = 0;
    int               rr = 0;
    int               out_beats = 0;
    logic [LANES-1:0] acc = '0;
    bit               idle_flag = 1'b0;

    int  len    [LANES];
    int  idx    [LANES];
    bit  active [LANES];
    int  cyc = 0;

    always @(negedge clk) begin
      logic [LANES-1:0] exp_rdy;
      beat_t            b;
      int               pick;
      if (!rst_n) begin
        q.delete();
        locked    = 1'b0;
        lane      = 0;
        rr        = 0;
        out_beats = 0;
        acc       = '0;
      end else begin
        exp_rdy = '0;
        if (locked && q.size() < 2) exp_rdy[lane] = 1'b1;
        check($sformatf("i%0d tready", gi), s_tready, exp_rdy);
        check($sformatf("i%0d grant_valid", gi), gvalid, locked);
        if (locked) check($sformatf("i%0d grant_lane", gi), glane, lane);
        check($sformatf("i%0d m_tvalid", gi), m_tvalid, q.size() > 0);
        if (m_tvalid && q.size() > 0) begin
          check($sformatf("i%0d m_tdata", gi), m_tdata, q[0].d);
          check($sformatf("i%0d m_tkeep", gi), m_tkeep, q[0].k);
          check($sformatf("i%0d m_tlast", gi), m_tlast, q[0].l);
        end

        acc = s_tvalid & s_tready;

        if (m_tvalid && m_tready && q.size() > 0) begin
          b = q.pop_front();
          out_beats++;
          if (b.l) begin
            $display("inst %0d: frame from lane %0d delivered, %0d beats", gi, b.ln, out_beats);
            out_beats = 0;
          end
        end

        if (!locked) begin
          if (|s_tvalid) begin
            pick = -1;
            for (int k = 0; k < LANES; k++) begin
              int c;
              c = (gi == 0) ? (rr + k) % LANES : k;
              if (pick < 0 && s_tvalid[c]) pick = c;
            end
            locked = 1'b1;
            lane   = pick;
          end
        end else begin
          for (int l = 0; l < LANES; l++) begin
            if (acc[l]) begin
              b.d  = s_tdata[l*DATA_W +: DATA_W];
              b.k  = s_tkeep[l*KEEP_W +: KEEP_W];
              b.l  = s_tlast[l];
              b.ln = l;
              q.push_back(b);
              if (s_tlast[l] && l == lane) begin
                locked = 1'b0;
                rr     = (lane + 1) % LANES;
              end
            end
          end
        end
      end
      idle_flag = (q.size() == 0) && !locked && (s_tvalid == '0);
      for (int l = 0; l < LANES; l++) if (active[l]) idle_flag = 1'b0;
    end

    // Sources and sink, updated just after each rising edge.
    always @(posedge clk) begin
      #1;
      cyc++;
      if (!rst_n) begin
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        m_tready = 1'b0;
        for (int l = 0; l < LANES; l++) active[l] = 1'b0;
      end else begin
        for (int l = 0; l < LANES; l++) begin
          if (acc[l]) begin
            s_tvalid[l] = 1'b0;
            idx[l]++;
            if (idx[l] >= len[l]) active[l] = 1'b0;
          end
          if (!active[l] && allow_new && lane_mask[l] && $urandom_range(0, 99) < start_pct) begin
            active[l] = 1'b1;
            len[l]    = $urandom_range(len_min, len_max);
            idx[l]    = 0;
          end
          if (active[l] && !s_tvalid[l] && $urandom_range(0, 99) >= gap_pct) begin
            s_tvalid[l]                  = 1'b1;
            s_tdata[l*DATA_W +: DATA_W]  = incr ? DATA_W'(idx[l]) : $urandom;
            s_tkeep[l*KEEP_W +: KEEP_W]  = KEEP_W'($urandom_range(0, 15));
            s_tlast[l]                   = (idx[l] == len[l] - 1);
          end
        end
        case (ready_mode)
          0:       m_tready = 1'b1;
          1:       m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: m_tready = $urandom_range(0, 1) == 1;
        endcase
      end
    end

    // Asynchronous reset must clear every output without waiting for a clock.
    always @(negedge rst_n) begin
      #1;
      check($sformatf("i%0d rst m_tvalid", gi), m_tvalid, 0);
      check($sformatf("i%0d rst m_tdata", gi), m_tdata, 0);
      check($sformatf("i%0d rst m_tkeep", gi), m_tkeep, 0);
      check($sformatf("i%0d rst m_tlast", gi), m_tlast, 0);
      check($sformatf("i%0d rst tready", gi), s_tready, 0);
      check($sformatf("i%0d rst grant_valid", gi), gvalid, 0);
      check($sformatf("i%0d rst grant_lane", gi), glane, 0);
    end
  end

  initial begin
    bit found;
    bit done;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Single lane 1, 4-beat frames, free-running sink.
    set_knobs(1, 100, 4, 4, 0, 0, 0, 4'b0010);
    repeat (60) @(posedge clk);

    // All lanes streaming 2-beat frames back to back.
    set_knobs(1, 100, 2, 2, 0, 0, 0, 4'b1111);
    repeat (100) @(posedge clk);

    // Lanes 0 and 2 competing.
    set_knobs(1, 100, 3, 3, 0, 0, 0, 4'b0101);
    repeat (80) @(posedge clk);

    // 16-beat incrementing frames against a 1,0,0,1 ready pattern.
    set_knobs(1, 100, 16, 16, 1, 0, 1, 4'b1111);
    repeat (200) @(posedge clk);

    // Random frames, source gaps, random backpressure and lane masks.
    for (int i = 0; i < 40; i++) begin
      set_knobs(1, 30, 1, 6, 0, 30, 2, LANES'($urandom_range(1, 15)));
      repeat (50) @(posedge clk);
    end

    // Reset in the middle of traffic while the output holds a beat.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (g_inst[0].m_tvalid) found = 1'b1;
    end
    check("rst_mid wait for m_tvalid", found, 1);
    #1 rst_n = 1'b0;
    allow_new = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      set_knobs(1, 40, 1, 8, 0, 25, 2, LANES'($urandom_range(1, 15)));
      repeat (50) @(posedge clk);
    end

    // Let every source finish its frame and the mux drain.
    set_knobs(0, 0, 1, 1, 0, 0, 0, 4'b0000);
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (g_inst[0].idle_flag && g_inst[1].idle_flag) done = 1'b1;
    end
    check("drain complete", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_lane_mux.md
Name: axis_lane_mux

Overview:
- Parametrised N-lane AXI-Stream packet multiplexer with a registered output skid buffer.
- Successor to the single-lane pass-through skid stage.
- Arbitrates among LANES input streams at packet boundaries: round-robin or fixed priority.
- Forwards whole frames (tdata/tkeep/tlast) to a single TX stream at one beat per cycle, with full backpressure. It sits in front of the final TX interface and merges the wrapped-message lane (0) with the raw pass-through lane (1..).

Parameters:
- LANES, 2, number of input lanes (>=2); derived LANE_W = clog2(LANES).
- DATA_W, 32, tdata width in bits (multiple of 8).
- KEEP_W, DATA_W/8, tkeep width.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lane 0 highest).

Ports:
- tx_clk input 1 — single clock; all logic on its rising edge.
- tx_rst_n input 1 — asynchronous, active-low reset.
- s_axis_tvalid input LANES — per-lane valid.
- s_axis_tdata input LANES*DATA_W — lane i at [i*DATA_W +: DATA_W].
- s_axis_tkeep input LANES*KEEP_W — lane i at [i*KEEP_W +: KEEP_W].
- s_axis_tlast input LANES — per-lane last.
- s_axis_tready output LANES — per-lane ready.
- m_axis_tvalid output 1 — output valid, registered.
- m_axis_tdata output DATA_W — output data, registered.
- m_axis_tkeep output KEEP_W — output keep, registered.
- m_axis_tlast output 1 — output last, registered.
- m_axis_tready input 1 — downstream ready.
- grant_valid output 1 — high while a lane is locked (state LOCKED).
- grant_lane output LANE_W — currently or last granted lane.

Behaviour:
- Reset (async assert, sync deassert internally):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0.
  - s_axis_tready=0, grant_valid=0, grant_lane=0.
  - Round-robin pointer=0, skid entry empty, state IDLE.
  - Reset mid-packet discards all buffered beats; the downstream frame is truncated, with no tlast emitted.
- State machine IDLE / LOCKED:
  - IDLE: all s_axis_tready=0. If any s_axis_tvalid is high, select a lane:
    - ARB_MODE 0: first requesting lane at or after the rr pointer, wrapping LANES-1 -> 0.
    - ARB_MODE 1: lowest-index requesting lane.
    - Register grant_lane, go to LOCKED next cycle. If no request, stay in IDLE.
  - LOCKED: s_axis_tready[grant_lane] = internal ready; all other lanes' tready=0. Beat accepted when tvalid & tready on the granted lane. Accepting a beat with tlast=1 returns to IDLE next cycle; in mode 0 the rr pointer becomes grant_lane+1 (wrap).
  - grant_lane holds its value in IDLE until the next grant.
- Skid/output buffer:
  - Two entries: output register plus one skid register.
  - Internal ready = skid entry empty (registered).
  - Accepted beat with output empty, or output being consumed this cycle -> loads the output register.
  - Otherwise the beat goes to the skid register.
  - When the output is consumed and skid is full -> skid moves to output, skid empties.
  - Simultaneous consume + accept with skid full cannot occur, because ready=0 in that case.
- Data rules:
  - tdata/tkeep/tlast forwarded unmodified, including tkeep=0 beats.
  - m_axis_* hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- Latency: a beat accepted at cycle T appears on m_axis at T+1 when the output is free. Request seen in IDLE at cycle C -> first tready at C+1 -> first output beat at C+2.
- Throughput: 1 beat/cycle within a packet. One idle arbitration cycle between packets.
- Granted lane dropping tvalid mid-packet: the grant is held (no re-arbitration) until tlast.
- Ordering: no beat loss or duplication under any m_axis_tready pattern.

Test Plan:
- Reset: tx_rst_n=0 mid-packet with m_axis_tvalid=1 -> all outputs 0 immediately (async). After release: IDLE, grant_valid=0, and the next request grants lane 0 (mode 0).
- Single lane, 4-beat frame on lane 1 (0x11111111..0x44444444, last tkeep=4'b0011), m_axis_tready=1 -> first output beat 2 cycles after tvalid. Four consecutive beats, tlast on beat 4, tkeep=4'b0011.
- Round-robin, LANES=4, all lanes streaming 2-beat frames continuously -> grant order 0,1,2,3,0. Exactly one idle cycle between frames; no interleaving of lanes.
- Fixed priority (ARB_MODE=1), lanes 0 and 2 both requesting -> lane 0 served first. Lane 2 is served only once lane 0 is idle at an arbitration cycle.
- Backpressure: m_axis_tready toggling 1,0,0,1 every cycle during a 16-beat incrementing frame -> output is the exact sequence 0..15 with no gaps or duplicates. s_axis_tready drops only while the skid is full, and data holds stable while stalled.
- Mid-packet source gap: granted lane deasserts tvalid for 3 cycles while another lane requests -> grant unchanged. The other lane is served only after tlast.
